// File: rtl/punc_arb_pkg.sv
// punc_arb_pkg: shared encodings for the PUnC memory-port arbiter.
// States, owner tags, starvation defaults and the per-port command bundle.
package punc_arb_pkg;

  localparam logic [1:0] ARB_IDLE     = 2'd0;
  localparam logic [1:0] ARB_CPU_LOCK = 2'd1;
  localparam logic [1:0] ARB_DBG_LOCK = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  localparam int unsigned STARVE_LIMIT_DEF = 8;
  localparam int unsigned STARVE_W_DEF     = 4;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } arb_cmd_t;

endpackage

// File: rtl/punc_arb_starve_ctr.sv
// punc_arb_starve_ctr: saturating count of denied DBG-request cycles.
// hit_o flags that the DBG port must win the next IDLE arbitration.
module punc_arb_starve_ctr
  import punc_arb_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned W     = STARVE_W_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic gnt_i,
  output logic hit_o
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q < LIM) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == LIM);

endmodule

// File: rtl/punc_mem_arbiter.sv
// punc_mem_arbiter: one-access-per-cycle arbiter for the PUnC memory port.
// Optional DBG starvation guard enabled by PUNC_ARB_STARVE_EN.
module punc_mem_arbiter
  import punc_arb_pkg::*;
`ifdef PUNC_ARB_STARVE_EN
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned STARVE_W     = STARVE_W_DEF
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_lock,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        dbg_req,
  input  logic        dbg_lock,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic        cpu_gnt,
  output logic        dbg_gnt,
  output logic        cpu_rvalid,
  output logic        dbg_rvalid,
  output logic [15:0] rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  logic [1:0] state_q, state_d;
  logic       rvalid_q, rvalid_d;
  logic       own_q, own_d;
  logic       starve_hit;
  arb_cmd_t   cpu_cmd, dbg_cmd, win_cmd;

`ifdef PUNC_ARB_STARVE_EN
  punc_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT),
    .W     (STARVE_W)
  ) u_starve (
    .clk_i (clk),
    .rst_i (rst),
    .req_i (dbg_req),
    .gnt_i (dbg_gnt),
    .hit_o (starve_hit)
  );
`else
  assign starve_hit = 1'b0;
`endif

  assign cpu_cmd = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign dbg_cmd = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};

  // Grants are held low for the whole of reset, not just after it.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      case (state_q)
        ARB_IDLE: begin
          if (starve_hit && dbg_req) begin
            dbg_gnt = 1'b1;
          end else if (cpu_req) begin
            cpu_gnt = 1'b1;
          end else if (dbg_req) begin
            dbg_gnt = 1'b1;
          end
        end
        ARB_CPU_LOCK: cpu_gnt = cpu_req;
        ARB_DBG_LOCK: dbg_gnt = dbg_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    win_cmd = '0;
    unique case (1'b1)
      cpu_gnt: win_cmd = cpu_cmd;
      dbg_gnt: win_cmd = dbg_cmd;
      default: ;
    endcase
  end

  assign mem_en    = cpu_gnt | dbg_gnt;
  assign mem_we    = win_cmd.we;
  assign mem_addr  = win_cmd.addr;
  assign mem_wdata = win_cmd.wdata;

  // Dropping lock releases ownership whether or not the owner accessed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (cpu_gnt && cpu_lock) begin
          state_d = ARB_CPU_LOCK;
        end else if (dbg_gnt && dbg_lock) begin
          state_d = ARB_DBG_LOCK;
        end
      end
      ARB_CPU_LOCK: begin
        if (!cpu_lock) state_d = ARB_IDLE;
      end
      ARB_DBG_LOCK: begin
        if (!dbg_lock) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    rvalid_d = mem_en & ~mem_we;
    own_d    = own_q;
    if (rvalid_d) begin
      own_d = dbg_gnt ? OWN_DBG : OWN_CPU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      rvalid_q <= 1'b0;
      own_q    <= OWN_CPU;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      own_q    <= own_d;
    end
  end

  assign cpu_rvalid = rvalid_q && (own_q == OWN_CPU);
  assign dbg_rvalid = rvalid_q && (own_q == OWN_DBG);
  assign rdata      = mem_rdata;

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// tb_punc_mem_arbiter: directed bench with a read-return scoreboard
// and a synchronous memory model behind the arbiter.
module tb_punc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_lock, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        dbg_req, dbg_lock, dbg_we;
  logic [15:0] dbg_addr, dbg_wdata;
  logic        cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid;
  logic [15:0] rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [0:65535];

  typedef struct {
    logic        port;
    logic [15:0] data;
  } rd_t;

  rd_t sbq[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  punc_mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_lock   (cpu_lock),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .dbg_req    (dbg_req),
    .dbg_lock   (dbg_lock),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .cpu_gnt    (cpu_gnt),
    .dbg_gnt    (dbg_gnt),
    .cpu_rvalid (cpu_rvalid),
    .dbg_rvalid (dbg_rvalid),
    .rdata      (rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always @(posedge clk) begin
    if (rst) begin
      mem[16'h0010] <= 16'h0020;
      mem[16'h0020] <= 16'hCAFE;
      mem[16'h0030] <= 16'h1234;
      mem[16'h0041] <= 16'h5555;
      mem_rdata     <= 16'h0000;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic setcpu(input logic r, input logic l, input logic w,
                        input logic [15:0] a, input logic [15:0] d);
    cpu_req = r; cpu_lock = l; cpu_we = w;
    cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic setdbg(input logic r, input logic l, input logic w,
                        input logic [15:0] a, input logic [15:0] d);
    dbg_req = r; dbg_lock = l; dbg_we = w;
    dbg_addr = a; dbg_wdata = d;
  endtask

  task automatic push(input logic p, input logic [15:0] d);
    rd_t e;
    e.port = p;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic gnts(input string tag, input logic c, input logic d);
    chk({tag, "_cpu_gnt"}, {15'd0, cpu_gnt}, {15'd0, c});
    chk({tag, "_dbg_gnt"}, {15'd0, dbg_gnt}, {15'd0, d});
  endtask

  // Ends the current cycle and checks what the read return delivers.
  task automatic tick();
    rd_t e;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("rvalid_cpu", {15'd0, cpu_rvalid}, {15'd0, e.port == 1'b0});
      chk("rvalid_dbg", {15'd0, dbg_rvalid}, {15'd0, e.port == 1'b1});
      chk("rdata", rdata, e.data);
    end else begin
      chk("no_rvalid", {14'd0, cpu_rvalid, dbg_rvalid}, 16'd0);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic exp_d;
    rst = 1'b1;
    setcpu(1, 1, 1, 16'h1111, 16'h2222);
    setdbg(1, 1, 1, 16'h3333, 16'h4444);
    repeat (2) @(posedge clk);
    #1;
    gnts("rst", 0, 0);
    chk("rst_mem_en", {14'd0, mem_en, mem_we}, 16'd0);
    chk("rst_mem_addr", mem_addr, 16'd0);
    chk("rst_mem_wdata", mem_wdata, 16'd0);
    chk("rst_rvalid", {14'd0, cpu_rvalid, dbg_rvalid}, 16'd0);

    cyc();
    rst = 1'b0;
    setcpu(0, 0, 0, 0, 0);
    setdbg(0, 0, 0, 0, 0);
    #1;
    gnts("idle", 0, 0);
    chk("idle_mem_en", {15'd0, mem_en}, 16'd0);
    chk("idle_mem_addr", mem_addr, 16'd0);
    tick();

    cyc();
    setcpu(1, 0, 0, 16'h0030, 0);
    #1;
    gnts("cpu_rd", 1, 0);
    chk("cpu_rd_en_we", {14'd0, mem_en, mem_we}, 16'd2);
    chk("cpu_rd_addr", mem_addr, 16'h0030);
    push(0, 16'h1234);
    tick();

    cyc();
    setcpu(1, 0, 1, 16'h0040, 16'hBEEF);
    setdbg(1, 0, 0, 16'h0041, 0);
    #1;
    gnts("both", 1, 0);
    chk("both_we", {15'd0, mem_we}, 16'd1);
    chk("both_addr", mem_addr, 16'h0040);
    chk("both_wdata", mem_wdata, 16'hBEEF);
    tick();

    cyc();
    setcpu(0, 0, 0, 0, 0);
    #1;
    gnts("dbg_after", 0, 1);
    chk("dbg_after_addr", mem_addr, 16'h0041);
    push(1, 16'h5555);
    tick();

    cyc();
    setcpu(1, 0, 0, 16'h0040, 0);
    setdbg(0, 0, 0, 0, 0);
    #1;
    gnts("cpu_rd_beef", 1, 0);
    push(0, 16'hBEEF);
    tick();

    cyc();
    setcpu(0, 0, 0, 0, 0);
    setdbg(1, 0, 0, 16'h0041, 0);
    #1;
    gnts("dbg_b2b", 0, 1);
    push(1, 16'h5555);
    tick();

    cyc();
    setcpu(1, 1, 0, 16'h0010, 0);
    setdbg(0, 0, 0, 0, 0);
    #1;
    gnts("ldi_ptr", 1, 0);
    push(0, 16'h0020);
    tick();

    for (int i = 0; i < 3; i++) begin
      cyc();
      setcpu(0, 1, 0, 0, 0);
      setdbg(1, 0, 0, 16'h0041, 0);
      #1;
      gnts("ldi_hold", 0, 0);
      chk("ldi_hold_en", {15'd0, mem_en}, 16'd0);
      tick();
    end

    cyc();
    setcpu(1, 0, 0, 16'h0020, 0);
    #1;
    gnts("ldi_tgt", 1, 0);
    push(0, 16'hCAFE);
    tick();

    cyc();
    setcpu(0, 0, 0, 0, 0);
    #1;
    gnts("ldi_idle", 0, 1);
    push(1, 16'h5555);
    tick();

    for (int i = 0; i < 4; i++) begin
      cyc();
      setdbg(1, i < 3, 1, 16'h0050 + 16'(i), 16'hA000 + 16'(i));
      setcpu(i > 0, 0, 0, 16'h0030, 0);
      #1;
      gnts("burst", 0, 1);
      chk("burst_we", {15'd0, mem_we}, 16'd1);
      chk("burst_addr", mem_addr, 16'h0050 + 16'(i));
      chk("burst_wdata", mem_wdata, 16'hA000 + 16'(i));
      tick();
    end

    cyc();
    setdbg(0, 0, 0, 0, 0);
    #1;
    gnts("burst_end", 1, 0);
    push(0, 16'h1234);
    tick();

    for (int i = 0; i < 4; i++) begin
      cyc();
      setcpu(0, 0, 0, 0, 0);
      setdbg(1, 0, 0, 16'h0050 + 16'(i), 0);
      #1;
      gnts("burst_rd", 0, 1);
      push(1, 16'hA000 + 16'(i));
      tick();
    end

    cyc();
    setdbg(1, 1, 0, 16'h0041, 0);
    #1;
    gnts("abn_lock", 0, 1);
    push(1, 16'h5555);
    tick();

    cyc();
    setdbg(0, 1, 0, 0, 0);
    setcpu(1, 0, 0, 16'h0030, 0);
    #1;
    gnts("abn_held", 0, 0);
    tick();

    cyc();
    setdbg(0, 0, 0, 0, 0);
    #1;
    gnts("abn_drop", 0, 0);
    tick();

    cyc();
    #1;
    gnts("abn_idle", 1, 0);
    push(0, 16'h1234);
    tick();

    cyc();
    setcpu(0, 0, 0, 0, 0);
    tick();

    for (int i = 0; i < 18; i++) begin
      cyc();
      setcpu(1, 0, 0, 16'h0030, 0);
      setdbg(1, 0, 0, 16'h0041, 0);
`ifdef PUNC_ARB_STARVE_EN
      exp_d = (i == 8) || (i == 17);
`else
      exp_d = 1'b0;
`endif
      #1;
      gnts("starve", !exp_d, exp_d);
      if (exp_d) push(1, 16'h5555);
      else push(0, 16'h1234);
      tick();
    end

    cyc();
    setcpu(1, 1, 0, 16'h0010, 0);
    setdbg(1, 0, 0, 16'h0041, 0);
    #1;
    gnts("rl_lock", 1, 0);
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("rl_rvalid", {14'd0, cpu_rvalid, dbg_rvalid}, 16'd0);
    gnts("rl_rst", 0, 0);
    chk("rl_mem_en", {14'd0, mem_en, mem_we}, 16'd0);
    chk("rl_mem_addr", mem_addr, 16'd0);
    chk("rl_mem_wdata", mem_wdata, 16'd0);

    cyc();
    rst = 1'b0;
    setcpu(0, 1, 0, 0, 0);
    setdbg(1, 0, 0, 16'h0041, 0);
    #1;
    gnts("rl_idle", 0, 1);
    push(1, 16'h5555);
    tick();

    cyc();
    setcpu(0, 0, 0, 0, 0);
    setdbg(0, 0, 0, 0, 0);
    tick();
    chk("sb_empty", 16'(sbq.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
